i2s_axis_channel_scheduler: RTL and testbench
=============================================

Name: i2s_axis_channel_scheduler

Overview:
- Shares the single M00_AXIS master stream among I2S_RECEIVER_NUM per-channel I2S receiver sample FIFOs.
- Grants ready channels round-robin, pops one sample per grant, and tags each beat with its channel id.
- Groups beats into packets, asserting tlast every FRAME_BEATS beats or on a flush request.
- Sits between the receiver channel FIFOs and the AXIS output of the I2S receiver IP.

Parameters:
- I2S_RECEIVER_NUM, 32: number of channels, 2..256.
- I2S_DATA_BIT_WIDTH, 24: sample width.
- C_M00_AXIS_TDATA_WIDTH, 32: stream width. Must be >= I2S_DATA_BIT_WIDTH + 8; a violation is an elaboration error.
- FRAME_BEATS, 32: beats per tlast packet, >= 1.

Ports:
- m00_axis_aclk  in  1  sole clock.
- m00_axis_aresetn  in  1  synchronous, active-low reset.
- ch_enable  in  I2S_RECEIVER_NUM  per-channel grant enable.
- ch_ready  in  I2S_RECEIVER_NUM  channel FIFO non-empty (first-word-fall-through).
- ch_data  in  I2S_RECEIVER_NUM*I2S_DATA_BIT_WIDTH  FIFO head words; channel i occupies slice [i*W +: W].
- ch_rd_en  out  I2S_RECEIVER_NUM  one-hot FIFO pop strobe.
- frame_flush  in  1  single-cycle pulse: terminate the current packet early.
- m00_axis_tvalid  out  1
- m00_axis_tdata  out  C_M00_AXIS_TDATA_WIDTH
- m00_axis_tstrb  out  C_M00_AXIS_TDATA_WIDTH/8  constant all ones.
- m00_axis_tlast  out  1
- m00_axis_tready  in  1
- frame_count  out  32  count of packets completed, i.e. tlast beats accepted.
- busy  out  1  high in SEND.

Behaviour:
- Clock and reset: single clock m00_axis_aclk. m00_axis_aresetn is synchronous, active-low.
- Reset values: state=SCAN, rr_ptr=0, beat_cnt=0, flush_pend=0, tvalid=0, tdata=0, tlast=0, ch_rd_en=0, frame_count=0, busy=0.
- Reset mid-operation: an in-flight beat is dropped; tvalid is low on the cycle after the reset edge.
- State SCAN:
  - req = ch_enable & ch_ready.
  - Grant g is the first set req bit scanning rr_ptr, rr_ptr+1, …, wrapping at N-1→0.
  - If req != 0, on the same clock edge:
    - ch_rd_en[g] is high for exactly that one cycle;
    - tdata <= {zero pad, g[7:0], ch_data slice g}, sample in LSBs, id in bits [W+7:W];
    - tlast <= (beat_cnt==FRAME_BEATS-1) | flush_pend | frame_flush;
    - tvalid <= 1; rr_ptr <= (g==N-1)?0:g+1; state <= SEND.
  - If req == 0, stay in SCAN with ch_rd_en=0.
- State SEND:
  - tdata, tlast and tvalid are held stable until tready.
  - No ch_rd_en is asserted in SEND.
  - On tvalid&tready:
    - tvalid <= 0; state <= SCAN.
    - If tlast: beat_cnt <= 0, flush_pend <= 0, frame_count++ (wraps at 2^32).
    - Otherwise: beat_cnt++.
- Throughput: one beat per 2 cycles maximum, which is ample for audio rates.
- Latency: ch_ready→tvalid is 1 cycle when the channel wins the grant.
- frame_flush handling:
  - Sets flush_pend unless it is consumed in the same SCAN capture.
  - A flush pulse in SEND affects the next captured beat, not the current one.
  - Flush together with natural tlast produces one tlast and increments frame_count by 1.
  - Flush with no data pending: flush_pend is held until the next beat.
- ch_enable is sampled only in SCAN.
  - Disabling a channel never aborts a captured beat.
  - Disabling all channels stalls in SCAN; beat_cnt is retained.
- rr_ptr advances only on grants, giving a starvation-free rotation.
- A channel with ch_ready low is skipped without consuming a slot.

Decomposition:
- Package i2s_sched_pkg:
  - CH_ID_FIELD_W = 8;
  - clog2 function;
  - CH_ID_W = clog2(I2S_RECEIVER_NUM);
  - tdata field offsets (sample LSB = 0, id LSB = I2S_DATA_BIT_WIDTH);
  - state encoding SCAN/SEND.
- Sub-module i2s_rr_picker (combinational): req, rr_ptr → grant_valid, grant_idx. Implemented as rotate, find-first, un-rotate.

Test Plan:
- Reset, all enabled, only ch 5 ready with 0xABCDEF:
  - ch_rd_en = 32'h20 for 1 cycle;
  - next cycle tvalid=1, tdata=0x05ABCDEF, tlast=0;
  - after accept, rr_ptr=6.
- All 32 channels continuously ready, tready=1, FRAME_BEATS=32:
  - beats carry ids 0..31 in order, tlast only on id 31;
  - frame_count=1 after 64 cycles;
  - second frame again starts at id 0.
- Hold tready=0 for 10 cycles during SEND:
  - tdata/tlast/tvalid stable throughout, ch_rd_en=0;
  - on release, exactly one handshake, then a new grant.
- Ch 3 and ch 30 permanently ready:
  - grant sequence is 3,30,3,30 (wrap after 30);
  - setting ch_enable[3]=0 yields only 30.
- After 5 accepted beats, pulse frame_flush in SCAN together with a grant:
  - that 6th beat has tlast=1, frame_count +1;
  - next packet's natural tlast falls FRAME_BEATS beats later.
- Assert m00_axis_aresetn=0 during SEND with tready=0:
  - next cycle tvalid=0, frame_count=0;
  - after release, with chs 7 and 2 ready, first grant is 2 (rr_ptr=0).

Source files
------------

// File: rtl/i2s_sched_pkg.sv
// Purpose: shared constants, state encoding and helpers for the I2S channel scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package i2s_sched_pkg;

    // Channel id field carried in tdata is always a full byte.
    localparam int CH_ID_FIELD_W = 8;
    // Sample sits at the bottom of tdata.
    localparam int SAMPLE_LSB    = 0;

    typedef enum logic {
        SCAN = 1'b0,
        SEND = 1'b1
    } state_t;

    // Ceiling log2, floored at 1 so single-bit indices still get a width.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Channel id LSB sits directly above the sample.
    function automatic int id_lsb(input int sample_w);
        return sample_w;
    endfunction

endpackage

// File: rtl/i2s_rr_picker.sv
// Purpose: round-robin grant picker; rotates req by rr_ptr, finds first set bit, un-rotates.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a grant is consumed.
// Ports: req_i (request vector), rr_ptr_i (highest-priority index),
//        grant_valid_o (any request), grant_idx_o (winning index).
module i2s_rr_picker
    import i2s_sched_pkg::*;
#(
    parameter int N     = 32,
    parameter int IDX_W = clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic             grant_valid_o,
    output logic [IDX_W-1:0] grant_idx_o
);

    logic [2*N-1:0]   req_dbl;
    logic [N-1:0]     req_rot;
    logic [IDX_W-1:0] ff_idx;
    logic [IDX_W:0]   idx_sum;

    always_comb begin
        // Doubling the vector makes the rotate a plain part-select.
        req_dbl = {req_i, req_i};
        req_rot = req_dbl[rr_ptr_i +: N];

        // Lowest set bit of the rotated vector wins (loop runs high-to-low).
        ff_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                ff_idx = IDX_W'(i);
            end
        end

        // Un-rotate: add the pointer back modulo N.
        idx_sum = {1'b0, ff_idx} + {1'b0, rr_ptr_i};
        if (idx_sum >= (IDX_W + 1)'(N)) begin
            idx_sum = idx_sum - (IDX_W + 1)'(N);
        end

        grant_idx_o   = idx_sum[IDX_W-1:0];
        grant_valid_o = |req_i;
    end

endmodule

// File: rtl/i2s_axis_channel_scheduler.sv
// Purpose: round-robin mux of per-channel I2S sample FIFOs onto one AXIS master, id-tagged, tlast-framed.
// Latency: ch_ready to tvalid 1 cycle for the granted channel; at most one beat per 2 cycles.
// Backpressure: beat held stable in SEND until tready; no FIFO pop while a beat is outstanding.
// Ports: ch_enable/ch_ready/ch_data in, ch_rd_en one-hot pop out; frame_flush ends packet early;
//        m00_axis_* master stream; frame_count = tlast beats accepted; busy = beat outstanding.
module i2s_axis_channel_scheduler
    import i2s_sched_pkg::*;
#(
    parameter int I2S_RECEIVER_NUM       = 32,
    parameter int I2S_DATA_BIT_WIDTH     = 24,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int FRAME_BEATS            = 32
) (
    input  logic                                         m00_axis_aclk,
    input  logic                                         m00_axis_aresetn,
    input  logic [I2S_RECEIVER_NUM-1:0]                  ch_enable,
    input  logic [I2S_RECEIVER_NUM-1:0]                  ch_ready,
    input  logic [I2S_RECEIVER_NUM*I2S_DATA_BIT_WIDTH-1:0] ch_data,
    output logic [I2S_RECEIVER_NUM-1:0]                  ch_rd_en,
    input  logic                                         frame_flush,
    output logic                                         m00_axis_tvalid,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]            m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]          m00_axis_tstrb,
    output logic                                         m00_axis_tlast,
    input  logic                                         m00_axis_tready,
    output logic [31:0]                                  frame_count,
    output logic                                         busy
);

    localparam int N       = I2S_RECEIVER_NUM;
    localparam int W       = I2S_DATA_BIT_WIDTH;
    localparam int TDW     = C_M00_AXIS_TDATA_WIDTH;
    localparam int CH_ID_W = clog2(N);
    localparam int ID_LSB  = id_lsb(W);
    localparam logic [31:0] LAST_BEAT = 32'(FRAME_BEATS - 1);

    generate
        if (TDW < W + CH_ID_FIELD_W) begin : g_bad_width
            $error("C_M00_AXIS_TDATA_WIDTH must be >= I2S_DATA_BIT_WIDTH + 8");
        end
        if (N < 2 || N > 256) begin : g_bad_num
            $error("I2S_RECEIVER_NUM must be in 2..256");
        end
        if (FRAME_BEATS < 1) begin : g_bad_frame
            $error("FRAME_BEATS must be >= 1");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [CH_ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [31:0]        beat_cnt_q, beat_cnt_d;
    logic               flush_pend_q, flush_pend_d;
    logic               tvalid_q, tvalid_d;
    logic [TDW-1:0]     tdata_q, tdata_d;
    logic               tlast_q, tlast_d;
    logic [31:0]        frame_count_q, frame_count_d;

    logic [N-1:0]       req;
    logic               grant_valid;
    logic [CH_ID_W-1:0] grant_idx;

    assign req = ch_enable & ch_ready;

    i2s_rr_picker #(
        .N     (N),
        .IDX_W (CH_ID_W)
    ) u_picker (
        .req_i         (req),
        .rr_ptr_i      (rr_ptr_q),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
    );

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        beat_cnt_d    = beat_cnt_q;
        flush_pend_d  = flush_pend_q | frame_flush;
        tvalid_d      = tvalid_q;
        tdata_d       = tdata_q;
        tlast_d       = tlast_q;
        frame_count_d = frame_count_q;
        ch_rd_en      = '0;

        case (state_q)
            SCAN: begin
                if (grant_valid) begin
                    ch_rd_en[grant_idx]               = 1'b1;
                    tdata_d                           = '0;
                    tdata_d[SAMPLE_LSB +: W]          = ch_data[grant_idx*W +: W];
                    tdata_d[ID_LSB +: CH_ID_FIELD_W]  = CH_ID_FIELD_W'(grant_idx);
                    // A flush arriving with this capture is folded into this beat's tlast,
                    // so it must not also linger as a pending flush.
                    tlast_d      = (beat_cnt_q == LAST_BEAT) | flush_pend_q | frame_flush;
                    flush_pend_d = flush_pend_q;
                    tvalid_d     = 1'b1;
                    rr_ptr_d     = (grant_idx == CH_ID_W'(N - 1)) ? '0 : grant_idx + 1'b1;
                    state_d      = SEND;
                end
            end
            SEND: begin
                if (tvalid_q && m00_axis_tready) begin
                    tvalid_d = 1'b0;
                    state_d  = SCAN;
                    if (tlast_q) begin
                        beat_cnt_d    = '0;
                        // A flush seen in this same cycle belongs to the next packet.
                        flush_pend_d  = frame_flush;
                        frame_count_d = frame_count_q + 32'd1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 32'd1;
                    end
                end
            end
            default: state_d = SCAN;
        endcase

        // No FIFO pops while reset is held.
        if (!m00_axis_aresetn) begin
            ch_rd_en = '0;
        end
    end

    always_ff @(posedge m00_axis_aclk) begin
        if (!m00_axis_aresetn) begin
            state_q       <= SCAN;
            rr_ptr_q      <= '0;
            beat_cnt_q    <= '0;
            flush_pend_q  <= 1'b0;
            tvalid_q      <= 1'b0;
            tdata_q       <= '0;
            tlast_q       <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            beat_cnt_q    <= beat_cnt_d;
            flush_pend_q  <= flush_pend_d;
            tvalid_q      <= tvalid_d;
            tdata_q       <= tdata_d;
            tlast_q       <= tlast_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign m00_axis_tvalid = tvalid_q;
    assign m00_axis_tdata  = tdata_q;
    assign m00_axis_tlast  = tlast_q;
    assign m00_axis_tstrb  = '1;
    assign frame_count     = frame_count_q;
    assign busy            = (state_q == SEND);

endmodule

// File: tb/tb_i2s_axis_channel_scheduler.sv
// Purpose: self-checking bench for i2s_axis_channel_scheduler (vector table, corner sequences, random vs model).
// Latency: n/a.
// Backpressure: tready driven directly by the bench.
module tb_i2s_axis_channel_scheduler;

    localparam int N   = 32;
    localparam int W   = 24;
    localparam int TDW = 32;
    localparam int FB  = 32;

    logic              clk = 1'b0;
    logic              aresetn;
    logic [N-1:0]      en, rdy, rd_en;
    logic [N*W-1:0]    ch_data;
    logic [W-1:0]      ch_dat [N];
    logic              flush, tvalid, tlast, tready, busy;
    logic [TDW-1:0]    tdata;
    logic [TDW/8-1:0]  tstrb;
    logic [31:0]       fcnt;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pack
            assign ch_data[gi*W +: W] = ch_dat[gi];
        end
    endgenerate

    i2s_axis_channel_scheduler #(
        .I2S_RECEIVER_NUM       (N),
        .I2S_DATA_BIT_WIDTH     (W),
        .C_M00_AXIS_TDATA_WIDTH (TDW),
        .FRAME_BEATS            (FB)
    ) dut (
        .m00_axis_aclk    (clk),
        .m00_axis_aresetn (aresetn),
        .ch_enable        (en),
        .ch_ready         (rdy),
        .ch_data          (ch_data),
        .ch_rd_en         (rd_en),
        .frame_flush      (flush),
        .m00_axis_tvalid  (tvalid),
        .m00_axis_tdata   (tdata),
        .m00_axis_tstrb   (tstrb),
        .m00_axis_tlast   (tlast),
        .m00_axis_tready  (tready),
        .frame_count      (fcnt),
        .busy             (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic default_data();
        for (int i = 0; i < N; i++) ch_dat[i] = 24'h5A0000 | W'(i);
        ch_dat[5] = 24'hABCDEF;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        en = '0; rdy = '0; flush = 1'b0; tready = 1'b0;
        tick();
        tick();
        chk("rst tvalid", tvalid, 0);
        chk("rst tlast", tlast, 0);
        chk("rst tdata", tdata, 0);
        chk("rst frame_count", fcnt, 0);
        chk("rst busy", busy, 0);
        chk("rst rd_en", rd_en, 0);
        chk("rst tstrb", tstrb, 4'hF);
        aresetn = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0] en;
        logic [N-1:0] rdy;
        logic         tready;
        int           reps;
        logic [N-1:0] exp_rd;
        logic         exp_vld;
        logic [31:0]  exp_dat;
        logic         exp_last;
    } vec_t;

    function automatic vec_t mk(input logic [N-1:0] e, input logic [N-1:0] r, input logic tr,
                                input int reps, input logic [N-1:0] xr, input logic xv,
                                input logic [31:0] xd);
        vec_t v;
        v.en = e; v.rdy = r; v.tready = tr; v.reps = reps;
        v.exp_rd = xr; v.exp_vld = xv; v.exp_dat = xd; v.exp_last = 1'b0;
        return v;
    endfunction

    vec_t vt [15];

    // Behavioural reference model state (transaction level).
    bit          m_out;
    int          m_rr, m_beats, m_g;
    bit          m_fp, m_last;
    int unsigned m_frames;
    logic [31:0] m_dat;
    logic [N-1:0] m_req, exp_rd;

    initial begin
        logic [N-1:0] ea, en3, r330;
        int k, nb;

        ea   = '1;
        en3  = ~32'h8;
        r330 = 32'h4000_0008;
        vt[0]  = mk(ea,  32'h20,       1'b0, 1,  32'h20,       1'b1, 32'h05ABCDEF);
        vt[1]  = mk(ea,  32'h20,       1'b0, 10, 32'h0,        1'b1, 32'h05ABCDEF);
        vt[2]  = mk(ea,  32'h0,        1'b1, 1,  32'h0,        1'b0, 32'h0);
        vt[3]  = mk(ea,  32'h68,       1'b0, 1,  32'h40,       1'b1, 32'h065A0006);
        vt[4]  = mk(ea,  32'h0,        1'b1, 1,  32'h0,        1'b0, 32'h0);
        vt[5]  = mk(ea,  r330,         1'b1, 1,  32'h4000_0000, 1'b1, 32'h1E5A001E);
        vt[6]  = mk(ea,  r330,         1'b1, 1,  32'h0,        1'b0, 32'h0);
        vt[7]  = mk(ea,  r330,         1'b1, 1,  32'h8,        1'b1, 32'h035A0003);
        vt[8]  = mk(ea,  r330,         1'b1, 1,  32'h0,        1'b0, 32'h0);
        vt[9]  = mk(ea,  r330,         1'b1, 1,  32'h4000_0000, 1'b1, 32'h1E5A001E);
        vt[10] = mk(ea,  r330,         1'b1, 1,  32'h0,        1'b0, 32'h0);
        vt[11] = mk(en3, r330,         1'b1, 1,  32'h4000_0000, 1'b1, 32'h1E5A001E);
        vt[12] = mk(en3, r330,         1'b1, 1,  32'h0,        1'b0, 32'h0);
        vt[13] = mk(en3, r330,         1'b1, 1,  32'h4000_0000, 1'b1, 32'h1E5A001E);
        vt[14] = mk(en3, r330,         1'b1, 1,  32'h0,        1'b0, 32'h0);

        default_data();
        do_reset();

        // ---- table-driven vectors ----
        for (int i = 0; i < 15; i++) begin
            for (int r = 0; r < vt[i].reps; r++) begin
                en = vt[i].en; rdy = vt[i].rdy; tready = vt[i].tready;
                #1;
                chk($sformatf("vec%0d rd_en", i), rd_en, vt[i].exp_rd);
                tick();
                chk($sformatf("vec%0d tvalid", i), tvalid, vt[i].exp_vld);
                if (vt[i].exp_vld) begin
                    chk($sformatf("vec%0d tdata", i), tdata, vt[i].exp_dat);
                    chk($sformatf("vec%0d tlast", i), tlast, vt[i].exp_last);
                end
            end
        end

        // ---- all channels ready: ids in order, tlast on 31, second frame restarts ----
        do_reset();
        en = '1; rdy = '1; tready = 1'b1;
        k = 0;
        for (int c = 0; c < 64; c++) begin
            tick();
            if (tvalid) begin
                chk($sformatf("full id%0d", k), tdata[31:24], k);
                chk($sformatf("full last%0d", k), tlast, (k == 31));
                k++;
            end
        end
        chk("full beats", k, 32);
        chk("full frame_count", fcnt, 1);
        tick();
        chk("full 2nd tvalid", tvalid, 1);
        chk("full 2nd id", tdata[31:24], 0);

        // ---- flush with a grant after 5 beats, then natural tlast FB beats later ----
        do_reset();
        en = '1; rdy = 32'h200; tready = 1'b1;
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush tvalid", tvalid, 1);
        chk("flush tlast", tlast, 1);
        tick();
        chk("flush frame_count", fcnt, 1);
        nb = 0;
        for (int c = 0; c < 64; c++) begin
            tick();
            if (tvalid) begin
                nb++;
                chk($sformatf("post-flush last%0d", nb), tlast, (nb == FB));
            end
        end
        chk("post-flush beats", nb, FB);
        chk("post-flush frame_count", fcnt, 2);
        // Flush with no data pending is held until the next beat.
        rdy = '0; flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (3) tick();
        chk("idle-flush no beat", tvalid, 0);
        rdy = 32'h200;
        tick();
        chk("idle-flush tlast", tlast, 1);
        tick();
        chk("idle-flush frame_count", fcnt, 3);

        // ---- reset during SEND ----
        rdy = 32'h10; tready = 1'b0;
        tick();
        chk("preRst tvalid", tvalid, 1);
        aresetn = 1'b0;
        tick();
        chk("midRst tvalid", tvalid, 0);
        chk("midRst frame_count", fcnt, 0);
        chk("midRst rd_en", rd_en, 0);
        tick();
        aresetn = 1'b1;
        rdy = 32'h84;
        #1;
        chk("postRst rd_en", rd_en, 32'h4);
        tick();
        chk("postRst id", tdata[31:24], 2);

        // ---- randomized run against the behavioural model ----
        do_reset();
        m_out = 0; m_rr = 0; m_beats = 0; m_fp = 0; m_frames = 0; m_last = 0; m_dat = '0;
        for (int c = 0; c < 3000; c++) begin
            en     = ($urandom_range(0, 7) == 0) ? N'($urandom) : '1;
            rdy    = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom & $urandom);
            for (int i = 0; i < N; i++) ch_dat[i] = W'($urandom);
            tready = ($urandom_range(0, 2) != 0);
            flush  = ($urandom_range(0, 19) == 0);
            #1;
            exp_rd = '0;
            if (!m_out) begin
                m_req = en & rdy;
                m_g = -1;
                for (int j = 0; j < N; j++) begin
                    if (m_g < 0 && m_req[(m_rr + j) % N]) m_g = (m_rr + j) % N;
                end
                if (m_g >= 0) begin
                    exp_rd[m_g] = 1'b1;
                    m_dat  = {8'(m_g), ch_dat[m_g]};
                    m_last = (m_beats == FB - 1) || m_fp || flush;
                    m_out  = 1;
                    m_rr   = (m_g + 1) % N;
                end else begin
                    m_fp = m_fp | flush;
                end
            end else if (tready) begin
                m_out = 0;
                if (m_last) begin
                    m_beats = 0; m_frames++; m_fp = flush;
                end else begin
                    m_beats++; m_fp = m_fp | flush;
                end
            end else begin
                m_fp = m_fp | flush;
            end
            chk("rnd rd_en", rd_en, exp_rd);
            tick();
            chk("rnd tvalid", tvalid, m_out);
            chk("rnd busy", busy, m_out);
            if (m_out) begin
                chk("rnd tdata", tdata, m_dat);
                chk("rnd tlast", tlast, m_last);
            end
            chk("rnd frame_count", fcnt, m_frames);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
